cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Parametrised common-data-bus arbiter. It replaces the fixed two-unit, combinational, lowest-index-wins CDB mux in `core`. It accepts result requests from `N_UNITS` functional units and grants at most one per cycle, by round-robin or fixed priority. The granted result is broadcast on a registered CDB to the reservation stations, the reorder buffer and the register file. A flush input (branch miss) suppresses grants and kills the pending broadcast.

## Interface

Parameters:
- `N_UNITS`, default 2: number of requesting functional units, ≥1.
- `MODE`, default `ARB_RR`: arbitration policy, `arb_mode_t`. `ARB_RR` is round-robin. `ARB_FIXED` means lowest index wins.
- `CDB_W`, default `fcpu_pkg::CDB_W`: broadcast word width, `{rsv_id, data}`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `nrst`, input, 1: reset, asynchronous and active-high. Asserted = 1. The port name follows the core port list.
- `i_cdb`, input, `[N_UNITS][CDB_W]`: per-unit result words.
- `i_valid`, input, `[N_UNITS]`: per-unit request.
- `i_ready`, output, `[N_UNITS]`: per-unit grant. One-hot or zero.
- `flush`, input, 1: branch miss. Suppresses grants and kills the next broadcast.
- `cdb`, output, `CDB_W`: registered broadcast word.
- `cdb_valid`, output, 1: registered broadcast valid.
- `cdb_src`, output, `SRC_W = max(1, $clog2(N_UNITS))`: index of the unit that produced `cdb`.

## Operation

Handshake:
- A unit raises `i_valid[k]` and holds it and `i_cdb[k]` stable until the cycle where `i_valid[k] && i_ready[k]` (a transfer).
- Dropping `i_valid` before a transfer is permitted. It is a withdrawal and no transfer occurs.
- The CDB has no backpressure. The output register accepts a new word every cycle.

Grant logic, combinational:
- `i_ready` is all zero while `flush` is 1 or `nrst` is 1.
- `ARB_FIXED`: the lowest index `k` with `i_valid[k]` is granted.
- `ARB_RR`: search indices starting at `rr_ptr`, ascending, wrapping from `N_UNITS-1` to 0. The first valid index is granted.
- `i_ready` depends only on `i_valid`, `rr_ptr`, `flush` and `nrst`. It never depends on `i_cdb`.

Round-robin pointer `rr_ptr` (`SRC_W` bits):
- Reset value is 0.
- On a transfer from unit `w`: `rr_ptr <= (w == N_UNITS-1) ? 0 : w+1`.
- Unchanged on cycles without a transfer, including flush cycles.
- Unused when `MODE = ARB_FIXED`, held at 0.

Output register:
- On a transfer from `w`: `cdb <= i_cdb[w]`, `cdb_valid <= 1`, `cdb_src <= w`.
- With no transfer: `cdb <= 0`, `cdb_valid <= 0`, `cdb_src <= 0`.
- When `flush` is 1 in a cycle, that cycle produces no transfer, so the next cycle has `cdb_valid = 0`.
- A word already on `cdb` during the flush cycle still completes its broadcast. Consumers discard it by their own flush handling.

Boundary conditions:
- `N_UNITS = 1`: `i_ready[0] = i_valid[0] & ~flush`. `rr_ptr` stays 0.
- No requests: bus idle, `cdb = 0`.
- `nrst` asserted mid-broadcast: `cdb`, `cdb_valid`, `cdb_src` and `rr_ptr` clear immediately, asynchronously. `i_ready` is forced to 0.

## Timing

- Latency is 1 cycle from a transfer to `cdb_valid`.
- Throughput is one broadcast per cycle with no bubbles under continuous requests.
- `ARB_RR` fairness: a continuously requesting unit waits at most `N_UNITS-1` cycles for a grant.
- Reset values are all 0: `cdb`, `cdb_valid`, `cdb_src`, `rr_ptr`, `i_ready`.
- Reset release is synchronised by the top level. The first grant is possible in the first cycle with `nrst = 0`.

## Structure

- Add `typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_t` to `fcpu_pkg`.
- `CDB_W`, `RSV_ID_W` and `DATA_W` remain in `fcpu_pkg`.
- One combinational sub-module, `rr_priority_pick`. Parameter `N`. Inputs: `req[N]`, `start[SRC_W]`. Outputs: `grant` (one-hot) and `grant_idx`. `ARB_FIXED` drives `start = 0`.
- `core` instantiates the arbiter with `N_UNITS = 2`:
  - `units_cdb_valid` drives `i_valid`.
  - `units_cdb_ready` is driven by `i_ready`.
  - `branch_miss` drives `flush`.

## Test plan

1. Reset and idle: assert `nrst` while `cdb_valid = 1` and `cdb = 0x1234` → all outputs read 0 in the same cycle, before the next clock edge.
2. Round-robin, `N_UNITS = 4`, `ARB_RR`: all four units hold valid with words `0xA0..0xA3` → `cdb_src` cycles 0,1,2,3,0. Each `cdb` equals the granted word one cycle after its transfer.
3. Fixed priority, `N_UNITS = 4`, `ARB_FIXED`: units 0 and 2 both valid → unit 0 is granted every cycle. Unit 2 is granted in the first cycle after unit 0 drops valid.
4. Wrap-around: `rr_ptr = 3`, only unit 2 valid → unit 2 is granted, `rr_ptr` becomes 3. Then only unit 3 valid → unit 3 is granted, `rr_ptr` becomes 0.
5. Flush: all units valid and `flush = 1` for one cycle → `i_ready = 0`, `cdb_valid = 0` on the next cycle, `rr_ptr` unchanged. Arbitration resumes at the same index afterwards.
6. Single unit, `N_UNITS = 1`: continuous valid → broadcast every cycle with `cdb_src = 0`. A mid-stream `flush` produces exactly one idle bubble.

Source files
------------

// File: rtl/fcpu_pkg.sv
// fcpu_pkg: core-wide widths and types shared by the CDB arbiter and its users.
// A CDB word is {rsv_id, data}. The arbitration policy is chosen with arb_mode_t.
package fcpu_pkg;

  localparam int RSV_ID_W = 4;
  localparam int DATA_W   = 32;
  localparam int CDB_W    = RSV_ID_W + DATA_W;

  // ARB_RR rotates priority after every transfer; ARB_FIXED always favours the lowest index
  typedef enum logic {
    ARB_RR,
    ARB_FIXED
  } arb_mode_t;

  // Field view of a broadcast word, for consumers that want to split it
  typedef struct packed {
    logic [RSV_ID_W-1:0] rsvId;
    logic [DATA_W-1:0]   data;
  } cdb_word_t;

  // Width of a unit index; at least one bit so a single-unit build still has a src field
  function automatic int srcWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: bundles the functional-unit request side and the broadcast side
// of the common data bus. "master" is the unit/consumer side, "slave" the arbiter.
interface cdb_arbiter_if #(
  parameter int N_UNITS = 2,
  parameter int CDB_W   = fcpu_pkg::CDB_W
);

  localparam int SRC_W = fcpu_pkg::srcWidth(N_UNITS);

  // Request side: one result word and one valid per unit, grant returned per unit
  logic [N_UNITS-1:0][CDB_W-1:0] i_cdb;
  logic [N_UNITS-1:0]            i_valid;
  logic [N_UNITS-1:0]            i_ready;

  // Branch miss
  logic                          flush;

  // Registered broadcast
  logic [CDB_W-1:0]              cdb;
  logic                          cdb_valid;
  logic [SRC_W-1:0]              cdb_src;

  modport master (
    output i_cdb,
    output i_valid,
    output flush,
    input  i_ready,
    input  cdb,
    input  cdb_valid,
    input  cdb_src
  );

  modport slave (
    input  i_cdb,
    input  i_valid,
    input  flush,
    output i_ready,
    output cdb,
    output cdb_valid,
    output cdb_src
  );

endinterface

// File: rtl/cdb_arbiter_pick.sv
// rr_priority_pick: purely combinational rotating priority picker.
// The request vector is rotated so that index "start" sits at bit 0, the lowest
// set bit is isolated, and the one-hot result is rotated back. With start tied
// to 0 this degenerates to a plain lowest-index-wins picker.
module rr_priority_pick
  import fcpu_pkg::*;
#(
  parameter int N     = 2,
  parameter int SRC_W = srcWidth(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SRC_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [SRC_W-1:0] grant_idx
);

  logic [N-1:0] w_reqRot;
  logic [N-1:0] w_grantRot;
  int           w_rotIdx;
  int           w_sumIdx;

  // Rotate right by start: bit j of w_reqRot is req[(j + start) mod N]
  assign w_reqRot = N'({req, req} >> start);

  // Lowest set bit of the rotated request, both as one-hot and as an offset from start
  always_comb begin
    w_grantRot = '0;
    w_rotIdx   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_reqRot[k]) begin
        w_grantRot    = '0;
        w_grantRot[k] = 1'b1;
        w_rotIdx      = k;
      end
    end
  end

  // Rotate the one-hot back left by start to get the grant in unit numbering
  assign grant = N'(({w_grantRot, w_grantRot} << start) >> N);

  // Convert the offset back to an absolute index; reads 0 when nothing is requested
  always_comb begin
    w_sumIdx = w_rotIdx + int'(start);
    if (w_sumIdx >= N) begin
      w_sumIdx = w_sumIdx - N;
    end
    grant_idx = SRC_W'(w_sumIdx);
    if (w_reqRot == '0) begin
      grant_idx = '0;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: picks at most one functional-unit result per cycle and broadcasts
// it on a registered common data bus. Grants are combinational from the request
// vector and the round-robin pointer; the broadcast appears one cycle later.
// A branch miss (flush) blocks all grants, so the following cycle is idle, while
// a word already on the bus finishes its cycle untouched.
// nrst is active-high despite its name; the name matches the core port list.
module cdb_arbiter
  import fcpu_pkg::*;
#(
  parameter int        N_UNITS = 2,
  parameter arb_mode_t MODE    = ARB_RR,
  parameter int        CDB_W   = fcpu_pkg::CDB_W
) (
  input logic          clk,
  input logic          nrst,
  cdb_arbiter_if.slave bus
);

  localparam int SRC_W = srcWidth(N_UNITS);
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(N_UNITS - 1);

  logic [SRC_W-1:0]   r_rrPtr;
  logic [SRC_W-1:0]   w_start;
  logic [N_UNITS-1:0] w_grant;
  logic [SRC_W-1:0]   w_grantIdx;
  logic [N_UNITS-1:0] w_ready;
  logic               w_xfer;
  logic [CDB_W-1:0]   w_word;

  logic [CDB_W-1:0]   r_cdb;
  logic               r_cdbValid;
  logic [SRC_W-1:0]   r_cdbSrc;

  // Fixed priority always searches from unit 0; round-robin starts at the pointer
  assign w_start = (MODE == ARB_FIXED) ? '0 : r_rrPtr;

  rr_priority_pick #(
    .N     (N_UNITS),
    .SRC_W (SRC_W)
  ) u_pick (
    .req       (bus.i_valid),
    .start     (w_start),
    .grant     (w_grant),
    .grant_idx (w_grantIdx)
  );

  // Grants are gated by flush and reset; a grant is only ever given to a valid
  // unit, so any surviving grant bit is a transfer
  assign w_ready     = (bus.flush || nrst) ? '0 : w_grant;
  assign bus.i_ready = w_ready;
  assign w_xfer      = |w_ready;

  // One-hot AND-OR select of the granted unit's word; zero when nobody is granted
  always_comb begin
    w_word = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      w_word = w_word | (bus.i_cdb[k] & {CDB_W{w_ready[k]}});
    end
  end

  // Round-robin pointer: moves to the unit after the winner on each transfer,
  // wrapping to 0 after the last unit; idle and flush cycles leave it alone
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_rrPtr <= '0;
    end else if ((MODE == ARB_RR) && w_xfer) begin
      if (w_grantIdx == LAST_IDX) begin
        r_rrPtr <= '0;
      end else begin
        r_rrPtr <= w_grantIdx + 1'b1;
      end
    end
  end

  // Broadcast register: loads the winner's word and index, otherwise drives an idle bus of zeros
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_cdb      <= '0;
      r_cdbValid <= 1'b0;
      r_cdbSrc   <= '0;
    end else if (w_xfer) begin
      r_cdb      <= w_word;
      r_cdbValid <= 1'b1;
      r_cdbSrc   <= w_grantIdx;
    end else begin
      r_cdb      <= '0;
      r_cdbValid <= 1'b0;
      r_cdbSrc   <= '0;
    end
  end

  assign bus.cdb       = r_cdb;
  assign bus.cdb_valid = r_cdbValid;
  assign bus.cdb_src   = r_cdbSrc;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: drives three arbiter builds side by side (4-unit round-robin,
// 4-unit fixed priority, single unit) and compares grants and broadcasts
// against a reference model that simply searches the units in priority order.
module tb_cdb_arbiter;
  import fcpu_pkg::*;

  logic clk;
  logic nrst;
  int   total;
  int   bad;
  int   ptrRr;

  cdb_arbiter_if #(.N_UNITS(4)) busRr ();
  cdb_arbiter_if #(.N_UNITS(4)) busFx ();
  cdb_arbiter_if #(.N_UNITS(1)) busOne ();

  cdb_arbiter #(.N_UNITS(4), .MODE(ARB_RR)) dutRr (
    .clk  (clk),
    .nrst (nrst),
    .bus  (busRr.slave)
  );

  cdb_arbiter #(.N_UNITS(4), .MODE(ARB_FIXED)) dutFx (
    .clk  (clk),
    .nrst (nrst),
    .bus  (busFx.slave)
  );

  cdb_arbiter #(.N_UNITS(1), .MODE(ARB_RR)) dutOne (
    .clk  (clk),
    .nrst (nrst),
    .bus  (busOne.slave)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: first requesting unit met when walking upward from ptr with wrap-around
  function automatic int pickRef(input logic [3:0] v, input int n, input int ptr);
    for (int off = 0; off < n; off++) begin
      int k;
      k = (ptr + off) % n;
      if (v[2'(k)]) return k;
    end
    return -1;
  endfunction

  // All request-side inputs of every build back to idle
  task automatic applyStimulus;
    busRr.i_valid  = '0;
    busRr.i_cdb    = '0;
    busRr.flush    = 1'b0;
    busFx.i_valid  = '0;
    busFx.i_cdb    = '0;
    busFx.flush    = 1'b0;
    busOne.i_valid = '0;
    busOne.i_cdb   = '0;
    busOne.flush   = 1'b0;
  endtask

  // Reset state, idle bus, and asynchronous clear of a live broadcast
  task automatic test_reset;
    nrst = 1'b1;
    applyStimulus();
    busRr.i_valid  = 4'hF;
    busFx.i_valid  = 4'hF;
    busOne.i_valid = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({busRr.i_ready, busFx.i_ready, busOne.i_ready} !== 9'd0) begin
      bad++;
      $display("[TB] FAIL reset_ready got=%b want=0", {busRr.i_ready, busFx.i_ready, busOne.i_ready});
    end
    total++;
    if ({busRr.cdb_valid, busRr.cdb, busRr.cdb_src} !== 39'd0) begin
      bad++;
      $display("[TB] FAIL reset_rr_out got v=%b cdb=%h src=%0d want 0", busRr.cdb_valid, busRr.cdb, busRr.cdb_src);
    end
    total++;
    if ({busFx.cdb_valid, busFx.cdb, busFx.cdb_src} !== 39'd0) begin
      bad++;
      $display("[TB] FAIL reset_fx_out got v=%b cdb=%h src=%0d want 0", busFx.cdb_valid, busFx.cdb, busFx.cdb_src);
    end
    total++;
    if ({busOne.cdb_valid, busOne.cdb, busOne.cdb_src} !== 38'd0) begin
      bad++;
      $display("[TB] FAIL reset_one_out got v=%b cdb=%h src=%0d want 0", busOne.cdb_valid, busOne.cdb, busOne.cdb_src);
    end

    @(negedge clk);
    nrst = 1'b0;
    applyStimulus();
    @(posedge clk); #1;
    total++;
    if ({busRr.cdb_valid, busRr.cdb} !== 37'd0) begin
      bad++;
      $display("[TB] FAIL idle_bus got v=%b cdb=%h want 0", busRr.cdb_valid, busRr.cdb);
    end

    @(negedge clk);
    busFx.i_valid  = 4'b0010;
    busFx.i_cdb[1] = 36'h1234;
    @(posedge clk); #1;
    total++;
    if ({busFx.cdb_valid, busFx.cdb, busFx.cdb_src} !== {1'b1, 36'h1234, 2'd1}) begin
      bad++;
      $display("[TB] FAIL pre_reset_bcast got v=%b cdb=%h src=%0d want v=1 cdb=1234 src=1",
               busFx.cdb_valid, busFx.cdb, busFx.cdb_src);
    end
    #2;
    nrst = 1'b1;
    #1;
    total++;
    if ({busFx.cdb_valid, busFx.cdb, busFx.cdb_src} !== 39'd0) begin
      bad++;
      $display("[TB] FAIL async_clear got v=%b cdb=%h src=%0d want 0", busFx.cdb_valid, busFx.cdb, busFx.cdb_src);
    end
    total++;
    if (busFx.i_ready !== 4'd0) begin
      bad++;
      $display("[TB] FAIL async_ready got=%b want=0000", busFx.i_ready);
    end
    @(negedge clk);
    nrst = 1'b0;
    applyStimulus();
    ptrRr = 0;
  endtask

  // All four round-robin units request continuously: winners 0,1,2,3,0 with no bubbles
  task automatic test_round_robin;
    int expSrc[5] = '{0, 1, 2, 3, 0};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        for (int k = 0; k < 4; k++) busRr.i_cdb[k] = 36'(32'hA0 + k);
        busRr.i_valid = 4'hF;
      end
      #1;
      total++;
      if (busRr.i_ready !== 4'(1 << expSrc[c])) begin
        bad++;
        $display("[TB] FAIL rr_ready c=%0d got=%b want=%b", c, busRr.i_ready, 4'(1 << expSrc[c]));
      end
      @(posedge clk); #1;
      total++;
      if ({busRr.cdb_valid, busRr.cdb, busRr.cdb_src} !== {1'b1, 36'(32'hA0 + expSrc[c]), 2'(expSrc[c])}) begin
        bad++;
        $display("[TB] FAIL rr_bcast c=%0d got v=%b cdb=%h src=%0d want v=1 cdb=%h src=%0d",
                 c, busRr.cdb_valid, busRr.cdb, busRr.cdb_src, 36'(32'hA0 + expSrc[c]), expSrc[c]);
      end
      ptrRr = (expSrc[c] + 1) % 4;
    end
    @(negedge clk);
    applyStimulus();
  endtask

  // Fixed priority: unit 0 beats unit 2 until it withdraws, then unit 2 wins at once
  task automatic test_fixed;
    logic [3:0] vals[5] = '{4'b0101, 4'b0101, 4'b0101, 4'b0100, 4'b0100};
    int         winner[5] = '{0, 0, 0, 2, 2};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) busFx.i_cdb[k] = 36'(32'hB0 + k);
      busFx.i_valid = vals[c];
      #1;
      total++;
      if (busFx.i_ready !== 4'(1 << winner[c])) begin
        bad++;
        $display("[TB] FAIL fx_ready c=%0d got=%b want=%b", c, busFx.i_ready, 4'(1 << winner[c]));
      end
      @(posedge clk); #1;
      total++;
      if ({busFx.cdb_valid, busFx.cdb, busFx.cdb_src} !== {1'b1, 36'(32'hB0 + winner[c]), 2'(winner[c])}) begin
        bad++;
        $display("[TB] FAIL fx_bcast c=%0d got v=%b cdb=%h src=%0d want src=%0d",
                 c, busFx.cdb_valid, busFx.cdb, busFx.cdb_src, winner[c]);
      end
    end
    @(negedge clk);
    applyStimulus();
  endtask

  // Pointer wrap: reach pointer 3 via unit 2, then unit 3 wraps it to 0
  task automatic test_wrap;
    logic [3:0] vals[4] = '{4'b0100, 4'b0100, 4'b1000, 4'b1111};
    int         winner[4] = '{2, 2, 3, 0};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) busRr.i_cdb[k] = 36'(32'hC0 + k);
      busRr.i_valid = vals[c];
      #1;
      total++;
      if (busRr.i_ready !== 4'(1 << winner[c])) begin
        bad++;
        $display("[TB] FAIL wrap_ready c=%0d got=%b want=%b", c, busRr.i_ready, 4'(1 << winner[c]));
      end
      @(posedge clk); #1;
      total++;
      if (busRr.cdb_src !== 2'(winner[c]) || busRr.cdb_valid !== 1'b1) begin
        bad++;
        $display("[TB] FAIL wrap_src c=%0d got v=%b src=%0d want v=1 src=%0d", c, busRr.cdb_valid, busRr.cdb_src, winner[c]);
      end
      ptrRr = (winner[c] + 1) % 4;
    end
    @(negedge clk);
    applyStimulus();
  endtask

  // Flush: no grant, next cycle idle, pointer kept, the in-flight word still finishes
  task automatic test_flush;
    int first;
    first = ptrRr;
    @(negedge clk);
    for (int k = 0; k < 4; k++) busRr.i_cdb[k] = 36'(32'hD0 + k);
    busRr.i_valid = 4'hF;
    @(posedge clk); #1;
    ptrRr = (first + 1) % 4;
    @(negedge clk);
    busRr.flush = 1'b1;
    #1;
    total++;
    if (busRr.i_ready !== 4'd0) begin
      bad++;
      $display("[TB] FAIL flush_ready got=%b want=0000", busRr.i_ready);
    end
    total++;
    if ({busRr.cdb_valid, busRr.cdb} !== {1'b1, 36'(32'hD0 + first)}) begin
      bad++;
      $display("[TB] FAIL flush_inflight got v=%b cdb=%h want v=1 cdb=%h", busRr.cdb_valid, busRr.cdb, 36'(32'hD0 + first));
    end
    @(posedge clk); #1;
    total++;
    if ({busRr.cdb_valid, busRr.cdb, busRr.cdb_src} !== 39'd0) begin
      bad++;
      $display("[TB] FAIL flush_bubble got v=%b cdb=%h src=%0d want 0", busRr.cdb_valid, busRr.cdb, busRr.cdb_src);
    end
    @(negedge clk);
    busRr.flush = 1'b0;
    #1;
    total++;
    if (busRr.i_ready !== 4'(1 << ptrRr)) begin
      bad++;
      $display("[TB] FAIL flush_resume got=%b want=%b", busRr.i_ready, 4'(1 << ptrRr));
    end
    @(posedge clk); #1;
    total++;
    if (busRr.cdb_src !== 2'(ptrRr) || busRr.cdb_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL flush_resume_src got v=%b src=%0d want v=1 src=%0d", busRr.cdb_valid, busRr.cdb_src, ptrRr);
    end
    ptrRr = (ptrRr + 1) % 4;
    @(negedge clk);
    applyStimulus();
  endtask

  // Single unit streaming continuously; one flush cycle costs exactly one bubble
  task automatic test_single;
    logic [CDB_W-1:0] word;
    int               bubbles;
    logic             fl;
    bubbles = 0;
    word    = {4'($urandom), 32'($urandom)};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      fl = (c == 3);
      busOne.i_valid  = 1'b1;
      busOne.i_cdb[0] = word;
      busOne.flush    = fl;
      #1;
      total++;
      if (busOne.i_ready !== ~fl) begin
        bad++;
        $display("[TB] FAIL one_ready c=%0d got=%b want=%b", c, busOne.i_ready, ~fl);
      end
      @(posedge clk); #1;
      total++;
      if ({busOne.cdb_valid, busOne.cdb, busOne.cdb_src} !== (fl ? 38'd0 : {1'b1, word, 1'b0})) begin
        bad++;
        $display("[TB] FAIL one_bcast c=%0d got v=%b cdb=%h src=%0d want v=%b", c, busOne.cdb_valid, busOne.cdb, busOne.cdb_src, ~fl);
      end
      if (!busOne.cdb_valid) bubbles++;
      if (!fl) word = {4'($urandom), 32'($urandom)};
    end
    total++;
    if (bubbles != 1) begin
      bad++;
      $display("[TB] FAIL one_bubbles got=%0d want=1", bubbles);
    end
    @(negedge clk);
    applyStimulus();
  endtask

  // Random requests, withdrawals and flushes on all three builds against the model
  task automatic test_random;
    logic [3:0]       vR, vF, vPrevR, vPrevF;
    logic             vO, fR, fF, fO;
    logic [CDB_W-1:0] wR[4];
    logic [CDB_W-1:0] wF[4];
    logic [CDB_W-1:0] wO;
    int               iR, iF, iO, lastR, lastF;
    logic [38:0]      expR, expF;
    logic [37:0]      expO;
    vPrevR = '0; vPrevF = '0; lastR = -1; lastF = -1;
    for (int k = 0; k < 4; k++) begin
      wR[k] = '0;
      wF[k] = '0;
    end
    wO = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      vR = 4'($urandom_range(0, 15));
      vF = 4'($urandom_range(0, 15));
      vO = 1'($urandom_range(0, 1));
      fR = ($urandom_range(0, 7) == 0);
      fF = ($urandom_range(0, 7) == 0);
      fO = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < 4; k++) begin
        if (!vPrevR[k] || k == lastR) wR[k] = {4'($urandom), 32'($urandom)};
        if (!vPrevF[k] || k == lastF) wF[k] = {4'($urandom), 32'($urandom)};
        busRr.i_cdb[k] = wR[k];
        busFx.i_cdb[k] = wF[k];
      end
      wO = {4'($urandom), 32'($urandom)};
      busRr.i_valid = vR;   busRr.flush  = fR;
      busFx.i_valid = vF;   busFx.flush  = fF;
      busOne.i_valid = vO;  busOne.flush = fO;
      busOne.i_cdb[0] = wO;
      #1;
      iR = fR ? -1 : pickRef(vR, 4, ptrRr);
      iF = fF ? -1 : pickRef(vF, 4, 0);
      iO = fO ? -1 : pickRef({3'b000, vO}, 1, 0);
      total++;
      if (busRr.i_ready !== ((iR < 0) ? 4'd0 : 4'(1 << iR))) begin
        bad++;
        $display("[TB] FAIL rand_rr_ready c=%0d got=%b want_idx=%0d", c, busRr.i_ready, iR);
      end
      total++;
      if (busFx.i_ready !== ((iF < 0) ? 4'd0 : 4'(1 << iF))) begin
        bad++;
        $display("[TB] FAIL rand_fx_ready c=%0d got=%b want_idx=%0d", c, busFx.i_ready, iF);
      end
      total++;
      if (busOne.i_ready !== (iO == 0)) begin
        bad++;
        $display("[TB] FAIL rand_one_ready c=%0d got=%b want=%b", c, busOne.i_ready, iO == 0);
      end
      expR = (iR < 0) ? 39'd0 : {1'b1, wR[iR], 2'(iR)};
      expF = (iF < 0) ? 39'd0 : {1'b1, wF[iF], 2'(iF)};
      expO = (iO < 0) ? 38'd0 : {1'b1, wO, 1'b0};
      @(posedge clk); #1;
      total++;
      if ({busRr.cdb_valid, busRr.cdb, busRr.cdb_src} !== expR) begin
        bad++;
        $display("[TB] FAIL rand_rr_bcast c=%0d got=%h want=%h", c, {busRr.cdb_valid, busRr.cdb, busRr.cdb_src}, expR);
      end
      total++;
      if ({busFx.cdb_valid, busFx.cdb, busFx.cdb_src} !== expF) begin
        bad++;
        $display("[TB] FAIL rand_fx_bcast c=%0d got=%h want=%h", c, {busFx.cdb_valid, busFx.cdb, busFx.cdb_src}, expF);
      end
      total++;
      if ({busOne.cdb_valid, busOne.cdb, busOne.cdb_src} !== expO) begin
        bad++;
        $display("[TB] FAIL rand_one_bcast c=%0d got=%h want=%h", c, {busOne.cdb_valid, busOne.cdb, busOne.cdb_src}, expO);
      end
      if (iR >= 0) ptrRr = (iR + 1) % 4;
      vPrevR = vR; vPrevF = vF; lastR = iR; lastF = iF;
    end
    @(negedge clk);
    applyStimulus();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    ptrRr = 0;
    test_reset();
    test_round_robin();
    test_fixed();
    test_wrap();
    test_flush();
    test_single();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
